// File: rtl/regfile_wr_sched_pkg.sv
// Shared register IDs, scheduler FSM encodings and the queued-write entry type
// for regfile_wr_sched and its write queue.
package regfile_wr_sched_pkg;

  localparam int WORD_W = 64;
  localparam int REG_W  = 4;

  typedef logic [REG_W-1:0] reg_id_t;

  localparam reg_id_t RAX   = 4'h0;
  localparam reg_id_t RCX   = 4'h1;
  localparam reg_id_t RDX   = 4'h2;
  localparam reg_id_t RBX   = 4'h3;
  localparam reg_id_t RSP   = 4'h4;
  localparam reg_id_t RBP   = 4'h5;
  localparam reg_id_t RSI   = 4'h6;
  localparam reg_id_t RDI   = 4'h7;
  localparam reg_id_t R8    = 4'h8;
  localparam reg_id_t R9    = 4'h9;
  localparam reg_id_t R10   = 4'hA;
  localparam reg_id_t R11   = 4'hB;
  localparam reg_id_t R12   = 4'hC;
  localparam reg_id_t R13   = 4'hD;
  localparam reg_id_t R14   = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DBG   = 2'd2;

  typedef struct packed {
    reg_id_t             dst;
    logic [WORD_W-1:0]   val;
  } wr_entry_t;

endpackage

// File: rtl/regfile_wr_sched_wr_queue.sv
// Pending register-write FIFO: two enqueue ports, one dequeue with empty-queue
// bypass of the first incoming entry, and two associative dst lookups.
module regfile_wr_sched_wr_queue
  import regfile_wr_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq0_valid_i,
  input  wr_entry_t          enq0_i,
  input  logic               enq1_valid_i,
  input  wr_entry_t          enq1_i,
  input  logic               deq_i,
  output logic               head_valid_o,
  output wr_entry_t          head_o,
  output logic [CNT_W-1:0]   count_o,
  input  reg_id_t            look_a_src_i,
  output logic               look_a_hit_o,
  output logic [WORD_W-1:0]  look_a_val_o,
  input  reg_id_t            look_b_src_i,
  output logic               look_b_hit_o,
  output logic [WORD_W-1:0]  look_b_val_o
);

  wr_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   n_enq;
  logic               deq;

  // Scan oldest to youngest so the youngest match wins.
  function automatic logic [WORD_W:0] lookup(
    input reg_id_t          src,
    input wr_entry_t        mem [DEPTH],
    input logic [PTR_W-1:0] rd,
    input logic [CNT_W-1:0] cnt
  );
    logic              hit;
    logic [WORD_W-1:0] val;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd + PTR_W'(i);
      if ((CNT_W'(i) < cnt) && (mem[idx].dst == src) && (src != RNONE)) begin
        hit = 1'b1;
        val = mem[idx].val;
      end
    end
    return {hit, val};
  endfunction

  assign head_valid_o = (count_q != '0) || enq0_valid_i;
  assign head_o       = (count_q != '0) ? mem_q[rd_ptr_q] : enq0_i;
  assign count_o      = count_q;
  assign deq          = deq_i && head_valid_o;
  assign n_enq        = CNT_W'(enq0_valid_i) + CNT_W'(enq1_valid_i);

  assign {look_a_hit_o, look_a_val_o} = lookup(look_a_src_i, mem_q, rd_ptr_q, count_q);
  assign {look_b_hit_o, look_b_val_o} = lookup(look_b_src_i, mem_q, rd_ptr_q, count_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
    count_d  = count_q + n_enq - CNT_W'(deq);
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq0_valid_i) begin
      mem_q[wr_ptr_q] <= enq0_i;
    end
    if (enq1_valid_i) begin
      mem_q[wr_ptr_q + PTR_W'(1)] <= enq1_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: serialises W-stage E/M writes, arbitrates
// a debug writer with starvation escape. Forwarding lookup: REGFILE_WR_SCHED_FWD_EN.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               W_valid_i,
  input  logic [3:0]         W_dstE_i,
  input  logic [63:0]        W_valE_i,
  input  logic [3:0]         W_dstM_i,
  input  logic [63:0]        W_valM_i,
  output logic               stall_o,
  input  logic               dbg_req_i,
  input  logic [3:0]         dbg_dst_i,
  input  logic [63:0]        dbg_val_i,
  output logic               dbg_gnt_o,
  output logic               wr_en_o,
  output logic [3:0]         wr_dst_o,
  output logic [63:0]        wr_val_o,
  input  logic [3:0]         fwd_srcA_i,
  input  logic [3:0]         fwd_srcB_i,
  output logic               fwdA_hit_o,
  output logic [63:0]        fwdA_val_o,
  output logic               fwdB_hit_o,
  output logic [63:0]        fwdB_val_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [1:0]         state_q, state_d;
  logic [STV_W-1:0]   starve_q, starve_d, starve_inc;
  logic               wr_en_q, wr_en_d;
  reg_id_t            wr_dst_q, wr_dst_d;
  logic [WORD_W-1:0]  wr_val_q, wr_val_d;

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   cnt_no_acc;
  logic [CNT_W-1:0]   free_slots;
  logic               q_empty;
  logic               e_valid, m_valid, accept, gnt;
  logic               enq0_valid, enq1_valid, head_valid;
  wr_entry_t          enq0, enq1, head;
  logic               qa_hit, qb_hit;
  logic [WORD_W-1:0]  qa_val, qb_val;

  // dstE == dstM collapses to the M write alone.
  assign e_valid = (W_dstE_i != RNONE) && (W_dstE_i != W_dstM_i);
  assign m_valid = (W_dstM_i != RNONE);

  assign q_empty    = (count == '0);
  assign cnt_no_acc = count - CNT_W'(!q_empty);
  assign free_slots = CNT_W'(DEPTH) - cnt_no_acc;
  assign stall_o    = (free_slots < CNT_W'(2)) || (state_q != ST_RUN);
  assign accept     = W_valid_i && !stall_o && (state_q == ST_RUN);

  assign enq0_valid = accept && (e_valid || m_valid);
  assign enq1_valid = accept && e_valid && m_valid;
  assign enq0       = e_valid ? {W_dstE_i, W_valE_i} : {W_dstM_i, W_valM_i};
  assign enq1       = {W_dstM_i, W_valM_i};

  regfile_wr_sched_wr_queue #(
    .DEPTH (DEPTH)
  ) u_wr_queue (
    .clk          (clk),
    .rst          (rst),
    .enq0_valid_i (enq0_valid),
    .enq0_i       (enq0),
    .enq1_valid_i (enq1_valid),
    .enq1_i       (enq1),
    .deq_i        (1'b1),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (count),
    .look_a_src_i (fwd_srcA_i),
    .look_a_hit_o (qa_hit),
    .look_a_val_o (qa_val),
    .look_b_src_i (fwd_srcB_i),
    .look_b_hit_o (qb_hit),
    .look_b_val_o (qb_val)
  );

  assign starve_inc = starve_q + STV_W'(1);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    gnt      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!dbg_req_i) begin
          starve_d = '0;
        end else if (q_empty && !accept) begin
          gnt      = 1'b1;
          starve_d = '0;
        end else if (starve_inc == STV_W'(STARVE_MAX)) begin
          starve_d = starve_inc;
          state_d  = ST_DRAIN;
        end else begin
          starve_d = starve_inc;
        end
      end
      ST_DRAIN: begin
        if (q_empty) begin
          state_d = ST_DBG;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DBG: begin
        gnt      = dbg_req_i;
        starve_d = '0;
        state_d  = ST_RUN;
      end
      default: begin
        starve_d = '0;
        state_d  = ST_RUN;
      end
    endcase
  end

  // Debug is only granted with no queued or incoming pipeline write, so it never overtakes one.
  always_comb begin
    wr_en_d  = 1'b0;
    wr_dst_d = RNONE;
    wr_val_d = '0;
    if (gnt) begin
      wr_en_d  = 1'b1;
      wr_dst_d = dbg_dst_i;
      wr_val_d = dbg_val_i;
    end else if (head_valid) begin
      wr_en_d  = 1'b1;
      wr_dst_d = head.dst;
      wr_val_d = head.val;
    end else begin
      wr_en_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      starve_q <= '0;
      wr_en_q  <= 1'b0;
      wr_dst_q <= RNONE;
      wr_val_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wr_en_q  <= wr_en_d;
      wr_dst_q <= wr_dst_d;
      wr_val_q <= wr_val_d;
    end
  end

  assign dbg_gnt_o = gnt && !rst;
  assign wr_en_o   = wr_en_q;
  assign wr_dst_o  = wr_dst_q;
  assign wr_val_o  = wr_val_q;

`ifdef REGFILE_WR_SCHED_FWD_EN
  // Queued entries take priority over the write already on the port.
  function automatic logic [WORD_W:0] fwd_pick(
    input logic              q_hit,
    input logic [WORD_W-1:0] q_val,
    input reg_id_t           src,
    input logic              en,
    input reg_id_t           dst,
    input logic [WORD_W-1:0] val
  );
    logic [WORD_W:0] res;
    if (q_hit) begin
      res = {1'b1, q_val};
    end else if (en && (dst == src) && (src != RNONE)) begin
      res = {1'b1, val};
    end else begin
      res = '0;
    end
    return res;
  endfunction

  assign {fwdA_hit_o, fwdA_val_o} = fwd_pick(qa_hit, qa_val, fwd_srcA_i, wr_en_q, wr_dst_q, wr_val_q);
  assign {fwdB_hit_o, fwdB_val_o} = fwd_pick(qb_hit, qb_val, fwd_srcB_i, wr_en_q, wr_dst_q, wr_val_q);
`else
  logic unused_fwd;
  assign unused_fwd = ^{qa_hit, qa_val, qb_hit, qb_val};
  assign fwdA_hit_o = 1'b0;
  assign fwdA_val_o = '0;
  assign fwdB_hit_o = 1'b0;
  assign fwdB_val_o = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched (DEPTH=4, STARVE_MAX=8); forwarding
// expectations follow REGFILE_WR_SCHED_FWD_EN.
module tb_regfile_wr_sched;

`ifdef REGFILE_WR_SCHED_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        W_valid_i;
  logic [3:0]  W_dstE_i, W_dstM_i;
  logic [63:0] W_valE_i, W_valM_i;
  logic        stall_o;
  logic        dbg_req_i;
  logic [3:0]  dbg_dst_i;
  logic [63:0] dbg_val_i;
  logic        dbg_gnt_o;
  logic        wr_en_o;
  logic [3:0]  wr_dst_o;
  logic [63:0] wr_val_o;
  logic [3:0]  fwd_srcA_i, fwd_srcB_i;
  logic        fwdA_hit_o, fwdB_hit_o;
  logic [63:0] fwdA_val_o, fwdB_val_o;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wr_sched #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .W_valid_i(W_valid_i), .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i),
    .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i), .stall_o(stall_o),
    .dbg_req_i(dbg_req_i), .dbg_dst_i(dbg_dst_i), .dbg_val_i(dbg_val_i),
    .dbg_gnt_o(dbg_gnt_o), .wr_en_o(wr_en_o), .wr_dst_o(wr_dst_o), .wr_val_o(wr_val_o),
    .fwd_srcA_i(fwd_srcA_i), .fwd_srcB_i(fwd_srcB_i),
    .fwdA_hit_o(fwdA_hit_o), .fwdA_val_o(fwdA_val_o),
    .fwdB_hit_o(fwdB_hit_o), .fwdB_val_o(fwdB_val_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] dst, input logic [63:0] val);
    chk({tag, ".en"}, 64'(wr_en_o), 64'(en));
    chk({tag, ".dst"}, 64'(wr_dst_o), 64'(dst));
    if (en) chk({tag, ".val"}, wr_val_o, val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_w();
    W_valid_i = 1'b0;
    W_dstE_i  = 4'hF;
    W_valE_i  = 64'h0;
    W_dstM_i  = 4'hF;
    W_valM_i  = 64'h0;
  endtask

  task automatic drive_w(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    W_valid_i = 1'b1;
    W_dstE_i  = de;
    W_valE_i  = ve;
    W_dstM_i  = dm;
    W_valM_i  = vm;
  endtask

  // Stream vector i = {E: dst i, 0x1000+i ; M: dst i+9, 0x2000+i}; write c is its c-th entry.
  task automatic drive_vec(input int i);
    drive_w(4'(i), 64'h1000 + 64'(i), 4'(i + 9), 64'h2000 + 64'(i));
  endtask

  task automatic pipe_wr(input int c, output logic [3:0] d, output logic [63:0] v);
    if (c % 2 == 0) begin
      d = 4'(c / 2);
      v = 64'h1000 + 64'(c / 2);
    end else begin
      d = 4'(c / 2 + 9);
      v = 64'h2000 + 64'(c / 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] bp_stall;
    logic [13:0] sv_stall, sv_gnt;
    logic [3:0]  ed;
    logic [63:0] ev;
    int          vi;

    bp_stall = 13'h0150;
    sv_stall = 14'h3F50;
    sv_gnt   = 14'h2000;

    rst = 1'b1;
    idle_w();
    dbg_req_i  = 1'b0;
    dbg_dst_i  = 4'h0;
    dbg_val_i  = 64'h0;
    fwd_srcA_i = 4'hF;
    fwd_srcB_i = 4'hF;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_wr("reset.wr", 1'b0, 4'hF, 64'h0);
    chk("reset.wr_val", wr_val_o, 64'h0);
    chk("reset.stall", 64'(stall_o), 64'h0);
    chk("reset.gnt", 64'(dbg_gnt_o), 64'h0);
    chk("reset.fwdA_hit", 64'(fwdA_hit_o), 64'h0);
    chk("reset.fwdB_val", fwdB_val_o, 64'h0);

    // Single E write
    drive_w(4'h0, 64'h5, 4'hF, 64'h0);
    tick();
    idle_w();
    chk_wr("single", 1'b1, 4'h0, 64'h5);
    tick();
    chk_wr("single.idle", 1'b0, 4'hF, 64'h0);

    // Dual write, E before M
    drive_w(4'h4, 64'h100, 4'h3, 64'h7);
    tick();
    idle_w();
    chk_wr("dual.e", 1'b1, 4'h4, 64'h100);
    tick();
    chk_wr("dual.m", 1'b1, 4'h3, 64'h7);
    tick();
    chk_wr("dual.idle", 1'b0, 4'hF, 64'h0);

    // Same destination keeps only M
    drive_w(4'h1, 64'h1, 4'h1, 64'h2);
    tick();
    idle_w();
    chk_wr("same", 1'b1, 4'h1, 64'h2);
    tick();
    chk_wr("same.idle", 1'b0, 4'hF, 64'h0);

    // Back-pressure: six dual vectors, each held until accepted
    vi = 0;
    for (int c = 0; c < 13; c++) begin
      if (vi < 6) drive_vec(vi);
      else idle_w();
      #1;
      chk("bp.stall", 64'(stall_o), 64'(bp_stall[c]));
      if (!bp_stall[c] && vi < 6) vi++;
      tick();
      if (c < 12) begin
        pipe_wr(c, ed, ev);
        chk_wr("bp.wr", 1'b1, ed, ev);
      end else begin
        chk_wr("bp.idle", 1'b0, 4'hF, 64'h0);
      end
    end
    chk("bp.all_accepted", 64'(vi), 64'd6);

    // Starvation: debug request denied 8 times, then drain and forced grant
    dbg_req_i = 1'b1;
    dbg_dst_i = 4'h8;
    dbg_val_i = 64'hAB;
    vi = 0;
    for (int c = 0; c < 14; c++) begin
      if (vi < 6) drive_vec(vi);
      else drive_w(4'hD, 64'h77, 4'hF, 64'h0);
      #1;
      chk("starve.stall", 64'(stall_o), 64'(sv_stall[c]));
      chk("starve.gnt", 64'(dbg_gnt_o), 64'(sv_gnt[c]));
      if (!sv_stall[c] && vi < 6) vi++;
      tick();
      if (c < 12) begin
        pipe_wr(c, ed, ev);
        chk_wr("starve.wr", 1'b1, ed, ev);
      end else if (c == 12) begin
        chk_wr("starve.gap", 1'b0, 4'hF, 64'h0);
      end else begin
        chk_wr("starve.dbg", 1'b1, 4'h8, 64'hAB);
      end
    end
    dbg_req_i = 1'b0;
    #1;
    chk("starve.post_stall", 64'(stall_o), 64'h0);
    chk("starve.post_gnt", 64'(dbg_gnt_o), 64'h0);
    tick();
    idle_w();
    chk_wr("starve.resume", 1'b1, 4'hD, 64'h77);
    tick();
    chk_wr("starve.idle", 1'b0, 4'hF, 64'h0);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive_vec(i);
      tick();
    end
    idle_w();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_wr("rstmid.wr", 1'b0, 4'hF, 64'h0);
    chk("rstmid.stall", 64'(stall_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("rstmid.nostale", 1'b0, 4'hF, 64'h0);
    end

    // Idle debug grant
    dbg_req_i = 1'b1;
    dbg_dst_i = 4'hA;
    dbg_val_i = 64'h5A;
    #1;
    chk("dbg.gnt", 64'(dbg_gnt_o), 64'h1);
    tick();
    dbg_req_i = 1'b0;
    #1;
    chk("dbg.gnt_drop", 64'(dbg_gnt_o), 64'h0);
    chk_wr("dbg.wr", 1'b1, 4'hA, 64'h5A);
    tick();
    chk_wr("dbg.idle", 1'b0, 4'hF, 64'h0);

    // Forwarding: queue ends up [RDX=3, RSI=0x66, RDX=9, RDI=0x77], RBP on the port
    drive_w(4'h0, 64'h10, 4'h3, 64'h13);
    tick();
    drive_w(4'h1, 64'h11, 4'h5, 64'h55);
    tick();
    drive_w(4'h2, 64'h3, 4'h6, 64'h66);
    tick();
    drive_w(4'h2, 64'h9, 4'h7, 64'h77);
    #1;
    chk("fwd.last_accept_stall", 64'(stall_o), 64'h0);
    tick();
    idle_w();
    fwd_srcA_i = 4'h2;
    fwd_srcB_i = 4'h6;
    #1;
    chk("fwd.full_stall", 64'(stall_o), 64'h1);
    chk_wr("fwd.port", 1'b1, 4'h5, 64'h55);
    chk("fwd.a_hit", 64'(fwdA_hit_o), FWD ? 64'h1 : 64'h0);
    chk("fwd.a_val", fwdA_val_o, FWD ? 64'h9 : 64'h0);
    chk("fwd.b_hit", 64'(fwdB_hit_o), FWD ? 64'h1 : 64'h0);
    chk("fwd.b_val", fwdB_val_o, FWD ? 64'h66 : 64'h0);
    fwd_srcB_i = 4'h5;
    #1;
    chk("fwd.port_hit", 64'(fwdB_hit_o), FWD ? 64'h1 : 64'h0);
    chk("fwd.port_val", fwdB_val_o, FWD ? 64'h55 : 64'h0);
    fwd_srcA_i = 4'hF;
    #1;
    chk("fwd.rnone_hit", 64'(fwdA_hit_o), 64'h0);
    tick();
    fwd_srcA_i = 4'h2;
    #1;
    chk_wr("fwd.port2", 1'b1, 4'h2, 64'h3);
    chk("fwd.young_over_port", fwdA_val_o, FWD ? 64'h9 : 64'h0);
    tick();
    chk_wr("fwd.drain_rsi", 1'b1, 4'h6, 64'h66);
    tick();
    chk_wr("fwd.drain_rdx", 1'b1, 4'h2, 64'h9);
    tick();
    chk_wr("fwd.drain_rdi", 1'b1, 4'h7, 64'h77);
    tick();
    chk_wr("fwd.idle", 1'b0, 4'hF, 64'h0);
    chk("fwd.idle_hit", 64'(fwdA_hit_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Write-port scheduler between the pipeline W stage and a single-write-port register file.
- Splits each W-stage retirement (dstE/valE plus dstM/valM) into at most two serialized register writes through a small pending queue.
- Shares the write port with a debug/loader requester, with starvation protection.
- Back-pressures the pipeline via stall_o.

Parameters:
- DEPTH, 4: pending-write queue entries (power of 2, minimum 2).
- STARVE_MAX, 8: consecutive cycles a debug request may be denied before forced service.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- W_valid_i  in  1  W stage holds a retiring instruction
- W_dstE_i  in  4  E destination register ID; 4'hF = RNONE
- W_valE_i  in  64  E value
- W_dstM_i  in  4  M destination register ID; 4'hF = RNONE
- W_valM_i  in  64  M value
- stall_o  out  1  W stage must hold; W_valid_i is ignored while high
- dbg_req_i  in  1  debug write request, level, held until granted
- dbg_dst_i  in  4  debug destination register ID
- dbg_val_i  in  64  debug value
- dbg_gnt_o  out  1  one-cycle grant pulse; the requester may drop or change the request the following cycle
- wr_en_o  out  1  register-file write enable (registered)
- wr_dst_o  out  4  register-file write ID (registered)
- wr_val_o  out  64  register-file write data (registered)
- fwd_srcA_i  in  4  forwarding lookup ID A
- fwd_srcB_i  in  4  forwarding lookup ID B
- fwdA_hit_o  out  1  forwarding hit for A
- fwdA_val_o  out  64  forwarding value for A
- fwdB_hit_o  out  1  forwarding hit for B
- fwdB_val_o  out  64  forwarding value for B

Clock is clk. Reset is rst: synchronous, active-high.

Behaviour:
- Reset values:
  - Queue empty, count = 0, starvation counter = 0, state RUN.
  - wr_en_o = 0, wr_dst_o = 4'hF, wr_val_o = 0.
  - dbg_gnt_o = 0, stall_o = 0, fwd hits = 0, fwd values = 0.
- Reset mid-operation discards all pending writes; no write is issued in the reset cycle.
- Accept rule: W is accepted when W_valid_i && !stall_o && state == RUN.
- Enqueue on accept, oldest first:
  - Entry E{W_dstE_i, W_valE_i} is enqueued if dstE != RNONE.
  - Entry M{W_dstM_i, W_valM_i} is enqueued if dstM != RNONE.
  - If dstE == dstM != RNONE, only M is enqueued (valM priority).
  - Both RNONE: accepted, nothing enqueued.
- Drain: each cycle the queue head (if any) is dequeued and presented on wr_* the next cycle. Latency from accept to first write is 1 cycle; the second write follows 1 cycle after that.
- Count arithmetic:
  - Count is $clog2(DEPTH)+1 bits.
  - Per cycle: count + enq(0..2) − deq(0..1).
  - Simultaneous enqueue and dequeue are legal.
  - Read/write pointers wrap modulo DEPTH.
- Stall rule: stall_o = (DEPTH − count_next_without_accept < 2) || state != RUN. It is combinational from registered state only and has no dependency on W_valid_i. Overflow is therefore impossible; a bench overflow check is an assertion failure.
- FSM:
  - RUN:
    - Debug is granted when dbg_req_i && queue empty && no accept this cycle. The grant drives dbg_gnt_o = 1 and issues the debug write on wr_* the next cycle; the starvation counter clears.
    - A denied dbg_req_i increments the starvation counter. When it reaches STARVE_MAX, go to DRAIN.
    - The counter clears whenever dbg_req_i is low.
  - DRAIN:
    - stall_o = 1, no accepts, queue keeps draining.
    - Once the queue is empty, go to DBG.
  - DBG:
    - stall_o = 1, dbg_gnt_o = 1, debug write issued next cycle, counter cleared.
    - Go to RUN.
- Debug writes never overtake queued pipeline writes to preserve ordering.
- wr_dst_o = 4'hF whenever wr_en_o = 0.

Optional Feature:
- Macro: REGFILE_WR_SCHED_FWD_EN.
- Defined:
  - fwdX_hit_o is combinational: set when any valid queue entry has dst == fwd_srcX_i and fwd_srcX_i != RNONE.
  - fwdX_val_o is the youngest matching entry's value.
  - The entry currently on wr_* (issued, not yet committed) also counts, at lowest priority.
- Undefined: hits and values are tied to 0, and the pipeline must stall on queue-pending hazards externally.

Decomposition:
- Shared package/define file: register ID constants (RAX..R14, RNONE = 4'hF), FSM state encodings (RUN/DRAIN/DBG), 64-bit word width constant.
- One natural sub-module, wr_queue: a DEPTH-entry FIFO with 2-in/1-out ports, count, and a parallel associative lookup used by the forwarding feature.

Test Plan:
- Single E write: W_valid, dstE = RAX (0), valE = 5, dstM = RNONE → cycle +1: wr_en = 1, wr_dst = 0, wr_val = 5; then idle with wr_dst = 4'hF.
- Dual write: dstE = RSP (4), valE = 0x100, dstM = RBX (3), valM = 7 → writes RSP = 0x100 at +1, RBX = 7 at +2, in that order.
- Same destination: dstE = dstM = RCX (1), valE = 1, valM = 2 → exactly one write, RCX = 2.
- Back-pressure: DEPTH = 4, present dual writes every cycle → stall_o rises once free slots < 2; no W accepted while it is high, none lost, write order matches issue order.
- Starvation: continuous dual writes with dbg_req = 1, dst = R8 (8), val = 0xAB → after 8 denials stall_o stays high, the queue drains, dbg_gnt pulses once, and R8 = 0xAB is written after the last queued write.
- Reset mid-drain: 3 entries queued, assert rst for 1 cycle → wr_en = 0 next cycle, count = 0, stall_o = 0, no stale writes afterwards.
- With REGFILE_WR_SCHED_FWD_EN: queue holds RDX = 3, then RDX = 9; fwd_srcA = RDX (2) → fwdA_hit = 1, fwdA_val = 9.
